fifo_value_reader: RTL and testbench

- Read-side companion to the change-triggered value-crossing FIFO.
- Lives entirely in the destination clock domain. Drives rdreq of a dual-clock FIFO in normal (non-show-ahead) mode and captures each word into a stable output register.
- Offers each captured word to a downstream consumer over a valid/ready handshake.
- Can suppress repeated values, and can enforce a minimum dwell time between consecutive updates.

---
 rtl/fifo_value_reader_if.sv | 18 +
 rtl/fifo_value_reader.sv | 96 +++++++++
 tb/tb_fifo_value_reader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_value_reader_if.sv
// fifo_value_reader_if: FIFO read side plus consumer handshake of the value reader
//   master (reader): drives rdreq, dataOut, valid, primed, wordCount; samples rdempty, q, ready
//   slave (FIFO/consumer side): the mirror image
interface fifo_value_reader_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 rdempty;
    logic                 rdreq;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     dataOut;
    logic                 valid;
    logic                 ready;
    logic                 primed;
    logic [CNT_WIDTH-1:0] wordCount;
    modport master (input rdempty, q, ready, output rdreq, dataOut, valid, primed, wordCount);
    modport slave (output rdempty, q, ready, input rdreq, dataOut, valid, primed, wordCount);
endinterface

// File: rtl/fifo_value_reader.sv
// fifo_value_reader: pops a non-show-ahead dual-clock FIFO one word at a time and offers it downstream
//   clk, reset_n (sync, active low)
//   bus.rdempty/rdreq/q : FIFO read port, rdreq registered, q valid the cycle after acceptance
//   bus.dataOut/valid/ready : captured value with valid/ready handshake
//   bus.primed : a word has been captured since reset; bus.wordCount : words popped, wraps
module fifo_value_reader #(
    parameter int WIDTH        = 8,
    parameter int CNT_WIDTH    = 16,
    parameter int MIN_HOLD     = 0,
    parameter int DROP_REPEATS = 0
) (
    input logic                 clk,
    input logic                 reset_n,
    fifo_value_reader_if.master bus
);
    localparam int HOLD_W = MIN_HOLD > 0 ? $clog2(MIN_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MIN_HOLD);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, OFFER, HOLD} state_t;
    state_t               state_q, state_d;
    logic                 rdreq_q, rdreq_d;
    logic                 valid_q, valid_d;
    logic                 primed_q, primed_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 drop;
    // a repeat only counts once something real has been captured, so a first word of 0 is kept
    assign drop = DROP_REPEATS != 0 && primed_q && bus.q == data_q;
    always_comb begin
        state_d  = state_q;
        rdreq_d  = rdreq_q;
        valid_d  = valid_q;
        primed_d = primed_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        case (state_q)
            IDLE: begin
                rdreq_d = !bus.rdempty;
                state_d = bus.rdempty ? IDLE : REQ;
            end
            REQ: begin
                rdreq_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d  = cnt_q + 1'b1;
                hold_d = HOLD_INIT;
                if (drop) begin
                    state_d = MIN_HOLD > 0 ? HOLD : IDLE;
                end else begin
                    data_d   = bus.q;
                    valid_d  = 1'b1;
                    primed_d = 1'b1;
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                hold_d = HOLD_INIT;
                if (bus.ready) begin
                    valid_d = 1'b0;
                    state_d = MIN_HOLD > 0 ? HOLD : IDLE;
                end
            end
            HOLD: begin
                hold_d  = hold_q - 1'b1;
                state_d = hold_q <= HOLD_W'(1) ? IDLE : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rdreq_q  <= 1'b0;
            valid_q  <= 1'b0;
            primed_q <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            rdreq_q  <= rdreq_d;
            valid_q  <= valid_d;
            primed_q <= primed_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
        end
    end
    assign bus.rdreq     = rdreq_q;
    assign bus.valid     = valid_q;
    assign bus.primed    = primed_q;
    assign bus.dataOut   = data_q;
    assign bus.wordCount = cnt_q;
endmodule

// File: tb/tb_fifo_value_reader.sv
// tb_fifo_value_reader: three reader configurations (plain, drop-repeats, dwell 5) against a FIFO model
module tb_fifo_value_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    logic rn[3] = '{1'b0, 1'b0, 1'b0};
    logic rdy[3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] mem[3][256];
    int wp[3] = '{0, 0, 0};
    wire rdreq_w[3];
    wire valid_w[3];
    wire primed_w[3];
    wire [7:0] dout_w[3];
    wire [3:0] wc_w[3];
    int cyc, dbl, unstable;
    int rq_t[$], vr_t[$], vf_t[$];
    logic [7:0] obs[$];
    logic pv, prq;
    logic [7:0] pd;
    for (genvar g = 0; g < 3; g++) begin : inst
        fifo_value_reader_if #(.WIDTH(8), .CNT_WIDTH(4)) bus ();
        int rp = 0;
        logic [7:0] qr = 8'h00;
        assign bus.rdempty = (rp == wp[g]);
        assign bus.q = qr;
        assign bus.ready = rdy[g];
        always @(posedge clk) if (bus.rdreq === 1'b1) begin
            qr <= mem[g][rp[7:0]];
            rp <= rp + 1;
        end
        fifo_value_reader #(.WIDTH(8), .CNT_WIDTH(4), .MIN_HOLD(g == 2 ? 5 : 0), .DROP_REPEATS(g == 1 ? 1 : 0)) dut (
            .clk(clk), .reset_n(rn[g]), .bus(bus));
        assign rdreq_w[g]  = bus.rdreq;
        assign valid_w[g]  = bus.valid;
        assign primed_w[g] = bus.primed;
        assign dout_w[g]   = bus.dataOut;
        assign wc_w[g]     = bus.wordCount;
    end
    task automatic push(int i, logic [7:0] v);
        mem[i][wp[i][7:0]] = v;
        wp[i]++;
    endtask
    task automatic do_reset(int i);
        rn[i] = 1'b0;
        @(negedge clk);
        rn[i] = 1'b1;
    endtask
    task automatic clear(int i);
        rq_t.delete(); vr_t.delete(); vf_t.delete(); obs.delete();
        cyc = 0; dbl = 0; unstable = 0;
        pv = valid_w[i]; prq = rdreq_w[i]; pd = dout_w[i];
    endtask
    task automatic collect(int i, int n, bit rnd);
        repeat (n) begin
            if (rnd) rdy[i] = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (rdreq_w[i]) begin
                rq_t.push_back(cyc);
                if (prq) dbl++;
            end
            if (valid_w[i] && !pv) begin
                vr_t.push_back(cyc);
                obs.push_back(dout_w[i]);
            end
            if (!valid_w[i] && pv) vf_t.push_back(cyc);
            if (valid_w[i] && pv && dout_w[i] !== pd) unstable++;
            pv = valid_w[i]; prq = rdreq_w[i]; pd = dout_w[i];
        end
    endtask
    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total += 5;
            if (rdreq_w[i] !== 1'b0) begin bad++; $display("FAIL reset_rdreq[%0d]: got %b want 0", i, rdreq_w[i]); end
            if (valid_w[i] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", i, valid_w[i]); end
            if (primed_w[i] !== 1'b0) begin bad++; $display("FAIL reset_primed[%0d]: got %b want 0", i, primed_w[i]); end
            if (dout_w[i] !== 8'h00) begin bad++; $display("FAIL reset_dout[%0d]: got %h want 00", i, dout_w[i]); end
            if (wc_w[i] !== 4'd0) begin bad++; $display("FAIL reset_count[%0d]: got %0d want 0", i, wc_w[i]); end
            rn[i] = 1'b1;
        end
    endtask
    task automatic test_single();
        do_reset(0);
        rdy[0] = 1'b1;
        clear(0);
        push(0, 8'hA5);
        collect(0, 8, 1'b0);
        total += 7;
        if (rq_t.size() != 1 || rq_t[0] != 1) begin bad++; $display("FAIL single_rdreq: got %0d pulses first at %0d want 1 at 1", rq_t.size(), rq_t[0]); end
        if (vr_t[0] != 3) begin bad++; $display("FAIL single_latency: got valid at %0d want 3", vr_t[0]); end
        if (vf_t[0] != 4) begin bad++; $display("FAIL single_valid_len: got fall at %0d want 4", vf_t[0]); end
        if (obs[0] !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", obs[0]); end
        if (dout_w[0] !== 8'hA5) begin bad++; $display("FAIL single_hold: got %h want a5", dout_w[0]); end
        if (primed_w[0] !== 1'b1) begin bad++; $display("FAIL single_primed: got %b want 1", primed_w[0]); end
        if (wc_w[0] !== 4'd1) begin bad++; $display("FAIL single_count: got %0d want 1", wc_w[0]); end
    endtask
    task automatic test_stream();
        logic [7:0] e[3] = '{8'h11, 8'h22, 8'h33};
        do_reset(0);
        rdy[0] = 1'b1;
        clear(0);
        for (int k = 0; k < 3; k++) push(0, e[k]);
        collect(0, 16, 1'b0);
        total += 4;
        if (obs.size() != 3) begin bad++; $display("FAIL stream_n: got %0d want 3", obs.size()); end
        if (rq_t.size() != 3) begin bad++; $display("FAIL stream_rdreq: got %0d want 3", rq_t.size()); end
        if (vr_t[1] - vr_t[0] != 4 || vr_t[2] - vr_t[1] != 4) begin bad++; $display("FAIL stream_spacing: got %0d,%0d want 4,4", vr_t[1] - vr_t[0], vr_t[2] - vr_t[1]); end
        if (wc_w[0] !== 4'd3) begin bad++; $display("FAIL stream_count: got %0d want 3", wc_w[0]); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== e[k]) begin bad++; $display("FAIL stream_data[%0d]: got %h want %h", k, obs[k], e[k]); end
        end
    endtask
    task automatic test_backpressure();
        do_reset(0);
        rdy[0] = 1'b0;
        clear(0);
        push(0, 8'h5A);
        push(0, 8'hC3);
        collect(0, 14, 1'b0);
        total += 5;
        if (vr_t.size() != 1 || vf_t.size() != 0) begin bad++; $display("FAIL bp_valid_held: got rises %0d falls %0d want 1 0", vr_t.size(), vf_t.size()); end
        if (dout_w[0] !== 8'h5A) begin bad++; $display("FAIL bp_data: got %h want 5a", dout_w[0]); end
        if (rq_t.size() != 1) begin bad++; $display("FAIL bp_no_read: got %0d pulses want 1", rq_t.size()); end
        if (unstable != 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
        if (valid_w[0] !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", valid_w[0]); end
        rdy[0] = 1'b1;
        collect(0, 6, 1'b0);
        total += 3;
        if (vf_t[0] != 15) begin bad++; $display("FAIL bp_release: got fall at %0d want 15", vf_t[0]); end
        if (rq_t[1] != 16) begin bad++; $display("FAIL bp_next_read: got %0d want 16", rq_t[1]); end
        if (obs[1] !== 8'hC3) begin bad++; $display("FAIL bp_second: got %h want c3", obs[1]); end
    endtask
    task automatic test_drop();
        do_reset(1);
        rdy[1] = 1'b1;
        clear(1);
        push(1, 8'h40); push(1, 8'h40); push(1, 8'h41);
        collect(1, 16, 1'b0);
        total += 5;
        if (obs.size() != 2) begin bad++; $display("FAIL drop_n: got %0d want 2", obs.size()); end
        if (obs[0] !== 8'h40) begin bad++; $display("FAIL drop_first: got %h want 40", obs[0]); end
        if (obs[1] !== 8'h41) begin bad++; $display("FAIL drop_second: got %h want 41", obs[1]); end
        if (wc_w[1] !== 4'd3) begin bad++; $display("FAIL drop_count: got %0d want 3", wc_w[1]); end
        if (rq_t.size() != 3) begin bad++; $display("FAIL drop_rdreq: got %0d want 3", rq_t.size()); end
    endtask
    task automatic test_hold();
        do_reset(2);
        rdy[2] = 1'b1;
        clear(2);
        push(2, 8'h01); push(2, 8'h02);
        collect(2, 24, 1'b0);
        total += 3;
        if (rq_t.size() != 2) begin bad++; $display("FAIL hold_rdreq: got %0d want 2", rq_t.size()); end
        if (rq_t[1] - vf_t[0] != 6) begin bad++; $display("FAIL hold_gap: got %0d want 6", rq_t[1] - vf_t[0]); end
        if (obs.size() != 2) begin bad++; $display("FAIL hold_n: got %0d want 2", obs.size()); end
    endtask
    task automatic test_reset_mid();
        do_reset(0);
        rdy[0] = 1'b1;
        clear(0);
        push(0, 8'h66); push(0, 8'h77);
        collect(0, 2, 1'b0);
        rn[0] = 1'b0;
        @(negedge clk);
        rn[0] = 1'b1;
        total += 5;
        if (rdreq_w[0] !== 1'b0) begin bad++; $display("FAIL mid_rdreq: got %b want 0", rdreq_w[0]); end
        if (valid_w[0] !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", valid_w[0]); end
        if (dout_w[0] !== 8'h00) begin bad++; $display("FAIL mid_dout: got %h want 00", dout_w[0]); end
        if (wc_w[0] !== 4'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", wc_w[0]); end
        if (primed_w[0] !== 1'b0) begin bad++; $display("FAIL mid_primed: got %b want 0", primed_w[0]); end
        clear(0);
        collect(0, 10, 1'b0);
        total += 2;
        if (obs.size() != 1 || obs[0] !== 8'h77) begin bad++; $display("FAIL mid_next: got %0d words first %h want 1 77", obs.size(), obs[0]); end
        if (wc_w[0] !== 4'd1) begin bad++; $display("FAIL mid_next_count: got %0d want 1", wc_w[0]); end
    endtask
    task automatic test_random(int i, bit drop, int n);
        logic [7:0] ex[$];
        logic [7:0] last = 8'h00;
        bit seen = 1'b0;
        do_reset(i);
        clear(i);
        for (int k = 0; k < n; k++) begin
            logic [7:0] w = drop ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            push(i, w);
            if (!(drop && seen && w == last)) ex.push_back(w);
            if (!(drop && seen && w == last)) last = w;
            seen = 1'b1;
        end
        collect(i, 300, 1'b1);
        rdy[i] = 1'b1;
        collect(i, 20, 1'b0);
        total += 6;
        if (obs.size() != ex.size()) begin bad++; $display("FAIL rand%0d_n: got %0d want %0d", i, obs.size(), ex.size()); end
        if (wc_w[i] !== 4'(n % 16)) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", i, wc_w[i], n % 16); end
        if (rq_t.size() != n) begin bad++; $display("FAIL rand%0d_rdreq: got %0d want %0d", i, rq_t.size(), n); end
        if (dbl != 0) begin bad++; $display("FAIL rand%0d_adjacent: got %0d want 0", i, dbl); end
        if (unstable != 0) begin bad++; $display("FAIL rand%0d_stable: got %0d want 0", i, unstable); end
        if (valid_w[i] !== 1'b0) begin bad++; $display("FAIL rand%0d_idle: got %b want 0", i, valid_w[i]); end
        for (int k = 0; k < ex.size(); k++) begin
            total++;
            if (obs[k] !== ex[k]) begin bad++; $display("FAIL rand%0d_data[%0d]: got %h want %h", i, k, obs[k], ex[k]); end
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_drop();
        test_hold();
        test_reset_mid();
        test_random(0, 1'b0, 20);
        test_random(1, 1'b1, 20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
